cook_sense: RTL and testbench

- Upstream conditioning stage for the cook FSM; produces its `temp` and `flip` inputs.
- `temp` comes from a stream of raw 8-bit temperature samples, qualified by a run-length filter with hysteresis.
- `flip` is a single-cycle pulse derived from an asynchronous, bouncy flip button.
- `need_flip` is fed back from the cook FSM so premature flips can optionally be suppressed and counted.

---
 rtl/cook_pkg.sv | 5 +
 rtl/flip_debounce.sv | 29 ++
 rtl/cook_sense.sv | 78 +++++++
 tb/tb_cook_sense.sv | 133 +++++++++++++
 4 files changed

// File: rtl/cook_pkg.sv
// cook_pkg: shared encodings for the temperature qualifier and the cook FSM status.
package cook_pkg;
   localparam logic [1:0] COLD = 2'b00, WARMING = 2'b01, HOT = 2'b11, COOLING = 2'b10;
   localparam logic [1:0] IDLE = 2'b00, NEED_FLIP = 2'b01, FLIPPED = 2'b10, DONE = 2'b11;
endpackage

// File: rtl/flip_debounce.sv
// flip_debounce: 2-FF synchroniser, stability counter and debounced-level rising-edge detect.
module flip_debounce #(
   parameter int DEB = 3
) (
   input  logic clk,
   input  logic reset,
   input  logic flip_btn,
   output logic rise
);
   localparam int DW = DEB > 1 ? $clog2(DEB) : 1;
   localparam logic [DW-1:0] LAST = DW'(DEB - 1);
   logic s1, s2, db, done;
   logic [DW-1:0] cnt;
   assign done = (s2 != db) && (cnt == LAST);
   // rise is the cycle before db goes high, so the pulse register lines up with db
   assign rise = done && s2;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         s1  <= 1'b0;
         s2  <= 1'b0;
         db  <= 1'b0;
         cnt <= '0;
      end else begin
         s1  <= flip_btn;
         s2  <= s1;
         db  <= done ? s2 : db;
         cnt <= (s2 == db || done) ? '0 : cnt + DW'(1);
      end
endmodule

// File: rtl/cook_sense.sv
// cook_sense: qualifies the temperature stream into temp and turns the flip button into a flip pulse.
module cook_sense import cook_pkg::*; #(
   parameter int SAMPLE_W  = 8,
   parameter int THRESH    = 180,
   parameter int HYST      = 10,
   parameter int HOLD      = 4,
   parameter int DEB       = 3,
   parameter int GATE_FLIP = 0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                sample_valid,
   input  logic [SAMPLE_W-1:0] sample,
   input  logic                flip_btn,
   input  logic                need_flip,
   output logic                temp,
   output logic                flip,
   output logic [3:0]          early_flips
);
   localparam int CW = $clog2(HOLD + 1);
   localparam logic [CW-1:0] LAST = CW'(HOLD - 1);
   localparam logic [SAMPLE_W-1:0] TH = SAMPLE_W'(THRESH);
   localparam logic [SAMPLE_W-1:0] TL = SAMPLE_W'(THRESH - HYST);
   logic [1:0] st, nst;
   logic [CW-1:0] cnt, ncnt;
   logic hi, lo, ntemp, rise;
   assign hi = sample >= TH;
   assign lo = sample < TL;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         st   <= COLD;
         cnt  <= '0;
         temp <= 1'b0;
      end else begin
         st   <= nst;
         cnt  <= ncnt;
         temp <= ntemp;
      end
   always_comb begin
      nst  = st;
      ncnt = cnt;
      if (sample_valid)
         case (st)
            COLD: begin
               nst  = hi ? (HOLD == 1 ? HOT : WARMING) : COLD;
               ncnt = (hi && HOLD != 1) ? CW'(1) : '0;
            end
            WARMING: begin
               nst  = !hi ? COLD : (cnt == LAST ? HOT : WARMING);
               ncnt = (!hi || cnt == LAST) ? '0 : cnt + CW'(1);
            end
            HOT: begin
               nst  = lo ? (HOLD == 1 ? COLD : COOLING) : HOT;
               ncnt = (lo && HOLD != 1) ? CW'(1) : '0;
            end
            default: begin
               nst  = !lo ? HOT : (cnt == LAST ? COLD : COOLING);
               ncnt = (!lo || cnt == LAST) ? '0 : cnt + CW'(1);
            end
         endcase
   end
   always_comb ntemp = (nst == HOT) || (nst == COOLING);
   flip_debounce #(.DEB(DEB)) u_deb (
      .clk      (clk),
      .reset    (reset),
      .flip_btn (flip_btn),
      .rise     (rise)
   );
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         flip        <= 1'b0;
         early_flips <= 4'd0;
      end else begin
         flip <= rise && (GATE_FLIP == 0 || need_flip);
         if (rise && GATE_FLIP != 0 && !need_flip && early_flips != 4'hf)
            early_flips <= early_flips + 4'd1;
      end
endmodule

// File: tb/tb_cook_sense.sv
// tb_cook_sense: scoreboard bench driving an ungated and a gated cook_sense with a shared stimulus stream.
module tb_cook_sense;
   localparam int HOLD = 4, DEB = 3;
   logic clk = 0, reset = 0, sample_valid = 0, flip_btn = 0, need_flip = 0;
   logic [7:0] sample = 0;
   logic temp0, flip0, temp1, flip1;
   logic [3:0] ef0, ef1;
   always #5 clk = ~clk;

   cook_sense #(.GATE_FLIP(0)) u0 (.clk(clk), .reset(reset), .sample_valid(sample_valid), .sample(sample),
      .flip_btn(flip_btn), .need_flip(need_flip), .temp(temp0), .flip(flip0), .early_flips(ef0));
   cook_sense #(.GATE_FLIP(1)) u1 (.clk(clk), .reset(reset), .sample_valid(sample_valid), .sample(sample),
      .flip_btn(flip_btn), .need_flip(need_flip), .temp(temp1), .flip(flip1), .early_flips(ef1));

   typedef struct packed {logic t; logic f0; logic f1; logic [3:0] e1;} exp_t;
   exp_t q[$];
   int tests = 0, fails = 0;
   // reference: temp level + run of qualifying samples; button seen two edges late, level changes after DEB differing edges
   int lvl, run, s1, s2, db, drun, early;
   logic b_cur = 0, n_cur = 0;
   int seq_a[4] = '{185, 190, 200, 181};
   int seq_b[7] = '{185, 185, 175, 185, 185, 185, 185};
   int seq_c[5] = '{160, 160, 160, 172, 160};

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      lvl = 0; run = 0; s1 = 0; s2 = 0; db = 0; drun = 0; early = 0;
   endtask

   task automatic step(input logic v, input int s);
      exp_t e;
      int rise;
      @(negedge clk);
      reset = 0; sample_valid = v; sample = 8'(s); flip_btn = b_cur; need_flip = n_cur;
      rise = 0;
      if (s2 != db) begin
         drun++;
         if (drun == DEB) begin db = s2; drun = 0; rise = db; end
      end else drun = 0;
      s2 = s1; s1 = b_cur;
      if (v) begin
         run = (lvl == 0 ? s >= 180 : s < 170) ? run + 1 : 0;
         if (run == HOLD) begin lvl = 1 - lvl; run = 0; end
      end
      if (rise != 0 && !n_cur && early < 15) early++;
      e.t = lvl[0]; e.f0 = rise[0]; e.f1 = rise[0] && n_cur; e.e1 = 4'(early);
      q.push_back(e);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1;
      #1;
      check("rst_temp0", temp0, 0); check("rst_flip0", flip0, 0); check("rst_ef0", ef0, 0);
      check("rst_temp1", temp1, 0); check("rst_flip1", flip1, 0); check("rst_ef1", ef1, 0);
      model_clear();
      q.push_back('0);
      @(negedge clk);
      q.push_back('0);
   endtask

   task automatic idle(input int n);
      repeat (n) step(0, 0);
   endtask

   task automatic press(input int hi_n, input int lo_n);
      b_cur = 1; idle(hi_n);
      b_cur = 0; idle(lo_n);
   endtask

   initial forever begin
      exp_t e;
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
         e = q.pop_front();
         check("temp0", temp0, e.t);
         check("temp1", temp1, e.t);
         check("flip0", flip0, e.f0);
         check("flip1", flip1, e.f1);
         check("early0", ef0, 0);
         check("early1", ef1, e.e1);
      end
   end

   initial begin
      int hold_n;
      #1 reset = 1;
      model_clear();
      do_reset();
      foreach (seq_a[i]) begin step(1, seq_a[i]); idle(1); end
      repeat (10) step(1, 175);
      foreach (seq_c[i]) step(1, seq_c[i]);
      repeat (4) step(1, 160);
      foreach (seq_b[i]) step(1, seq_b[i]);
      repeat (4) step(1, 150);
      press(2, 8);
      press(10, 8);
      n_cur = 0;
      repeat (17) press(6, 6);
      n_cur = 1;
      press(6, 6);
      n_cur = 0;
      b_cur = 1;
      step(1, 185); step(1, 185);
      do_reset();
      repeat (4) begin step(1, 185); idle(1); end
      idle(6);
      b_cur = 0;
      idle(6);
      hold_n = 0;
      repeat (1500) begin
         if (hold_n == 0) begin
            b_cur = 1'($urandom_range(0, 1));
            hold_n = $urandom_range(1, 7);
         end
         hold_n--;
         n_cur = 1'($urandom_range(0, 1));
         step($urandom_range(0, 3) != 0, $urandom_range(155, 200));
      end
      repeat (4) @(negedge clk);
      check("drain", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
